// File: rtl/midi_poly_processor.sv
// MIDI UART receiver, Note On/Off parser and polyphonic voice table with sticky irq/overflow.
// Optional MIDI_CHANNEL_FILTER_EN: execute only messages on channel control_in[7:4] (omni otherwise).
module midi_poly_processor #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 31250,
  parameter int NUM_VOICES = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      MIDI_RX,
  input  logic [7:0]                control_in,
  output logic                      irq,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic [7*NUM_VOICES-1:0]   voice_note,
  output logic [7*NUM_VOICES-1:0]   voice_vel,
  output logic [4*NUM_VOICES-1:0]   voice_chan,
  output logic                      overflow
);
  localparam int BIT_CLKS  = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS + 1);
  localparam int IW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} p_state_t;

  logic          rx_s1, rx_s2, rx_prev;
  u_state_t      u_state, u_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic          bit_end, half_end;

  assign bit_end  = (cnt == CW'(BIT_CLKS - 1));
  assign half_end = (cnt == CW'(HALF_CLKS - 1));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= MIDI_RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_comb begin
    u_next     = u_state;
    byte_valid = 1'b0;
    case (u_state)
      U_IDLE:  if (rx_prev && !rx_s2) u_next = U_START;
      U_START: if (half_end) u_next = rx_s2 ? U_IDLE : U_DATA;
      U_DATA:  if (bit_end && bit_idx == 3'd7) u_next = U_STOP;
      U_STOP: begin
        if (bit_end) begin
          u_next     = U_IDLE;
          byte_valid = rx_s2;  // low stop bit: framing error, byte dropped
        end
      end
      default: u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      u_state <= U_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      u_state <= u_next;
      if (u_state == U_IDLE || u_next != u_state || (u_state == U_DATA && bit_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (u_state == U_START)
        bit_idx <= 3'd0;
      if (u_state == U_DATA && bit_end) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  p_state_t   p_state, p_next;
  logic       rs_on;
  logic [3:0] rs_chan;
  logic [6:0] note_q;
  logic       fire, chan_ok, is_note_status;
  logic       ex_go, ex_on;
  logic [6:0] ex_note, ex_vel;
  logic [3:0] ex_chan;
  logic       unused_ctrl;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign chan_ok = (rs_chan == control_in[7:4]);
`else
  assign chan_ok = 1'b1;
`endif
  assign unused_ctrl    = ^control_in[7:2];
  assign is_note_status = (shreg[7:4] == 4'h8) || (shreg[7:4] == 4'h9);

  always_comb begin
    p_next = p_state;
    fire   = 1'b0;
    if (byte_valid) begin
      if (shreg[7]) begin
        if (is_note_status)
          p_next = P_DATA1;
        else if (shreg < 8'hF8)
          p_next = P_IDLE;  // real-time bytes leave state untouched
      end else begin
        case (p_state)
          P_DATA1: p_next = P_DATA2;
          P_DATA2: begin
            p_next = P_DATA1;
            fire   = chan_ok;
          end
          default: p_next = p_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      p_state <= P_IDLE;
      rs_on   <= 1'b0;
      rs_chan <= 4'd0;
      note_q  <= 7'd0;
      ex_go   <= 1'b0;
      ex_on   <= 1'b0;
      ex_note <= 7'd0;
      ex_vel  <= 7'd0;
      ex_chan <= 4'd0;
    end else begin
      p_state <= p_next;
      ex_go   <= fire;
      if (byte_valid && shreg[7] && is_note_status) begin
        rs_on   <= shreg[4];
        rs_chan <= shreg[3:0];
      end
      if (byte_valid && !shreg[7] && p_state == P_DATA1)
        note_q <= shreg[6:0];
      if (fire) begin
        ex_note <= note_q;
        ex_vel  <= shreg[6:0];
        ex_chan <= rs_chan;
        ex_on   <= rs_on && (shreg[6:0] != 7'd0);
      end
    end
  end

  logic          match_hit, free_hit, tbl_change, ovf_evt;
  logic [IW-1:0] match_idx, free_idx;

  // Descending scan so the last hit recorded is the lowest index.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_active[i] && voice_note[7*i +: 7] == ex_note && voice_chan[4*i +: 4] == ex_chan) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!voice_active[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign tbl_change = ex_go && (match_hit || (ex_on && free_hit));
  assign ovf_evt    = ex_go && ex_on && !match_hit && !free_hit;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      voice_active <= '0;
      voice_note   <= '0;
      voice_vel    <= '0;
      voice_chan   <= '0;
      irq          <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (ex_go) begin
        if (ex_on && match_hit) begin
          voice_vel[7*match_idx +: 7] <= ex_vel;
        end else if (ex_on && free_hit) begin
          voice_active[free_idx]      <= 1'b1;
          voice_note[7*free_idx +: 7] <= ex_note;
          voice_vel[7*free_idx +: 7]  <= ex_vel;
          voice_chan[4*free_idx +: 4] <= ex_chan;
        end else if (!ex_on && match_hit) begin
          voice_active[match_idx] <= 1'b0;
        end
      end
      if (control_in[1])
        irq <= 1'b0;
      else if (tbl_change && control_in[0])
        irq <= 1'b1;
      if (control_in[1])
        overflow <= 1'b0;
      else if (ovf_evt)
        overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_midi_poly_processor.sv
// Scoreboard bench: each expected output snapshot is queued before its stimulus; the monitor pops on every output change.
module tb_midi_poly_processor;
  localparam int NV   = 16;
  localparam int BITC = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic [7:0]      ctrl;
  logic            irq, overflow;
  logic [NV-1:0]   voice_active;
  logic [7*NV-1:0] voice_note, voice_vel;
  logic [4*NV-1:0] voice_chan;

  midi_poly_processor #(.CLK_HZ(16), .BAUD(1), .NUM_VOICES(NV)) dut (
    .clk(clk), .rstn(rst), .MIDI_RX(rx), .control_in(ctrl),
    .irq(irq), .voice_active(voice_active), .voice_note(voice_note),
    .voice_vel(voice_vel), .voice_chan(voice_chan), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            irq;
    logic            ovf;
    logic [NV-1:0]   act;
    logic [7*NV-1:0] note;
    logic [7*NV-1:0] vel;
    logic [4*NV-1:0] chan;
  } snap_t;

  snap_t exp_s, cur, prev, want;
  snap_t q[$];
  int    checks = 0, failures = 0, evn = 0;
  bit    mon_en = 1'b0, first = 1'b1;
  logic  irq_en;

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {irq, overflow, voice_active, voice_note, voice_vel, voice_chan};
      if (first || cur !== prev) begin
        first = 1'b0;
        prev  = cur;
        evn++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event%0d got=%h required=no_change", evn, cur);
        end else begin
          want = q.pop_front();
          if (cur !== want) begin
            failures++;
            $display("FAIL event%0d got=%h required=%h", evn, cur, want);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit good = 1'b1);
    rx = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BITC);
    end
    rx = good;
    tick(BITC);
    rx = 1'b1;
    tick(BITC);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  task automatic ev_set(input int i, input logic [6:0] n, input logic [6:0] v, input logic [3:0] c);
    exp_s.act[i]         = 1'b1;
    exp_s.note[7*i +: 7] = n;
    exp_s.vel[7*i +: 7]  = v;
    exp_s.chan[4*i +: 4] = c;
    exp_s.irq            = exp_s.irq | irq_en;
    q.push_back(exp_s);
  endtask

  task automatic ev_clr(input int i);
    exp_s.act[i] = 1'b0;
    exp_s.irq    = exp_s.irq | irq_en;
    q.push_back(exp_s);
  endtask

  task automatic ev_vel(input int i, input logic [6:0] v);
    exp_s.vel[7*i +: 7] = v;
    exp_s.irq           = exp_s.irq | irq_en;
    q.push_back(exp_s);
  endtask

  task automatic ev_ovf();
    exp_s.ovf = 1'b1;
    q.push_back(exp_s);
  endtask

  task automatic irq_clear(input logic [7:0] after);
    exp_s.irq = 1'b0;
    exp_s.ovf = 1'b0;
    q.push_back(exp_s);
    ctrl = after | 8'h02;
    tick(4);
    ctrl = after;
  endtask

  task automatic reset_now();
    exp_s = '0;
    q.push_back(exp_s);
    rst = 1'b1;
    rx  = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(BITC);
  endtask

  initial begin
    rx = 1'b1; ctrl = 8'h00; rst = 1'b1; exp_s = '0; irq_en = 1'b0;
    q.push_back(exp_s);
    tick(5);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(5);

    rx = 1'b0; tick(3); rx = 1'b1; tick(2 * BITC);  // start-bit glitch
    send3(8'h90, 8'h00, 8'h00);
    send3(8'h80, 8'h00, 8'h00);

    ctrl = 8'h01; irq_en = 1'b1;
    ev_set(0, 7'h42, 7'h69, 4'hA); send3(8'h9A, 8'h42, 8'h69);
    ev_clr(0);                     send3(8'h8A, 8'h42, 8'h69);

    irq_clear(8'h01);
    ev_set(0, 7'h35, 7'h64, 4'hA); send3(8'h9A, 8'h35, 8'h64);
    ev_set(1, 7'h34, 7'h64, 4'hA); send(8'h34); send(8'h64);
    ev_set(2, 7'h33, 7'h64, 4'hA); send(8'h33); send(8'h64);
    ev_clr(0); send3(8'h8A, 8'h35, 8'h40);
    ev_clr(2); send(8'h33); send(8'h40);
    ev_clr(1); send(8'h34); send(8'h40);

    send(8'h9A);
    for (int n = 1; n <= 15; n++) begin
      ev_set(n - 1, 7'(n), 7'h10, 4'hA);
      send(8'(n)); send(8'h10);
    end
    ev_set(15, 7'h69, 7'h20, 4'hA); send(8'h69); send(8'h20);
    ev_ovf();                       send(8'h42); send(8'h20);
    ev_vel(15, 7'h30);              send(8'h69); send(8'h30);
    ev_clr(9);                      send3(8'h8A, 8'h0A, 8'h00);
    ev_set(9, 7'h42, 7'h21, 4'hA);  send3(8'h9A, 8'h42, 8'h21);
    irq_clear(8'h01);

    ev_clr(0); send3(8'h8A, 8'h01, 8'h00);
    ev_clr(1); send(8'h02); send(8'h00);
    ev_set(0, 7'h10, 7'h40, 4'hA); send3(8'h9A, 8'h10, 8'h40);
    ev_set(1, 7'h11, 7'h40, 4'hA); send(8'h11); send(8'h40);
    ev_clr(0); send3(8'h8A, 8'h10, 8'h00);
    ev_set(0, 7'h20, 7'h50, 4'h5); send3(8'h95, 8'h20, 8'hF8); send(8'h50);
    ev_clr(0); send3(8'h85, 8'h20, 8'h00);
    ev_set(0, 7'h21, 7'h55, 4'h5); send(8'h95); send(8'h21); send(8'h60, 1'b0); send(8'h55);
    send3(8'hB0, 8'h30, 8'h40); send(8'h31); send(8'h40);  // no running status
    ev_clr(0); send3(8'h85, 8'h21, 8'h00);

    irq_clear(8'h00); irq_en = 1'b0;
    ev_set(0, 7'h22, 7'h33, 4'h5); send3(8'h95, 8'h22, 8'h33);
    ctrl = 8'h01; irq_en = 1'b1;
    ev_clr(0); send3(8'h85, 8'h22, 8'h00);
    ctrl = 8'h00; irq_en = 1'b0;
    ev_set(0, 7'h23, 7'h44, 4'h5); send3(8'h95, 8'h23, 8'h44);

    ctrl = 8'h01; irq_en = 1'b1;
    rx = 1'b0; tick(3 * BITC);
    reset_now();
    ev_set(0, 7'h50, 7'h60, 4'hA); send3(8'h9A, 8'h50, 8'h60);
    send(8'h9A); send(8'h51);
    reset_now();
    send(8'h60);
    ev_set(0, 7'h52, 7'h62, 4'hA); send3(8'h9A, 8'h52, 8'h62);

    for (int i = 0; i < 2000 && q.size() != 0; i++) tick(1);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
